// File: rtl/channel_drain_pkg.sv
// Shared DMA definitions: channel count, word size and the drain FSM encoding.
// Also hosts a one-hot to index helper used with the round-robin arbiter.
package channel_drain_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CH_W       = 2;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [1:0] {
        StArb,
        StRead,
        StCapt,
        StXfer
    } drain_state_e;

    function automatic logic [CH_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (oh[i]) idx = CH_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/channel_drain_if.sv
// One-word write bus between the drain engine (master) and the system bus (slave).
interface channel_drain_if #(
    parameter int unsigned ADDR_W = 32
);
    import channel_drain_pkg::*;

    logic              bus_valid;
    logic              bus_ready;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;

    modport master (output bus_valid, output bus_addr, output bus_wdata, input bus_ready);
    modport slave  (input bus_valid, input bus_addr, input bus_wdata, output bus_ready);

endinterface

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter: searches cyclically starting at ptr+1 and
// returns a one-hot grant (all zero when nothing requests).
module rr_arb4
    import channel_drain_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt
);

    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        // i = NUM_CH wraps back to ptr itself, so the last winner has lowest priority
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = ptr + CH_W'(i);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel_drain.sv
// Read-side DMA engine: drains four channel FIFOs round-robin, in bursts of up to
// BURST words, issuing one-word bus writes to each channel's advancing destination.
module channel_drain
    import channel_drain_pkg::*;
#(
    parameter int unsigned BURST  = 4,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_start,
    input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_done,
    output logic                     rd_0,
    output logic                     rd_1,
    output logic                     rd_2,
    output logic                     rd_3,
    input  logic [DATA_W-1:0]        rdata_0,
    input  logic [DATA_W-1:0]        rdata_1,
    input  logic [DATA_W-1:0]        rdata_2,
    input  logic [DATA_W-1:0]        rdata_3,
    input  logic                     empty_0,
    input  logic                     empty_1,
    input  logic                     empty_2,
    input  logic                     empty_3,
    channel_drain_if.master          bus
);

    localparam int unsigned BeatW = $clog2(BURST + 1);

    drain_state_e      state_q;
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   cur_q;
    logic [BeatW-1:0]  beat_q;
    logic [NUM_CH-1:0] rd_q;
    logic [NUM_CH-1:0] done_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] dst_q [NUM_CH];
    logic [LEN_W-1:0]  rem_q [NUM_CH];

    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_idx;
    logic [DATA_W-1:0] rdata [NUM_CH];

    assign empty = {empty_3, empty_2, empty_1, empty_0};

    always_comb begin
        rdata[0] = rdata_0;
        rdata[1] = rdata_1;
        rdata[2] = rdata_2;
        rdata[3] = rdata_3;
    end

    always_comb begin
        ch_busy = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_busy[n] = (rem_q[n] != '0);
        end
    end

    assign cand    = ch_busy & ~empty;
    assign gnt_idx = onehot_to_idx(gnt);

    rr_arb4 u_arb (
        .req (cand),
        .ptr (rr_q),
        .gnt (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StArb;
            rr_q    <= CH_W'(NUM_CH - 1);
            cur_q   <= '0;
            beat_q  <= '0;
            rd_q    <= '0;
            done_q  <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                dst_q[n] <= '0;
                rem_q[n] <= '0;
            end
        end else begin
            rd_q   <= '0;
            done_q <= '0;

            // Loads only land on idle channels, so they never collide with the
            // decrement of the channel currently being drained.
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_start[n] && !ch_busy[n] && ch_len[n*LEN_W +: LEN_W] != '0) begin
                    dst_q[n] <= ch_dst[n*ADDR_W +: ADDR_W];
                    rem_q[n] <= ch_len[n*LEN_W +: LEN_W];
                end
            end

            unique case (state_q)
                StArb: begin
                    if (|cand) begin
                        cur_q   <= gnt_idx;
                        rr_q    <= gnt_idx;
                        beat_q  <= '0;
                        rd_q    <= gnt;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    state_q <= StCapt;
                end
                StCapt: begin
                    wdata_q <= rdata[cur_q];
                    addr_q  <= dst_q[cur_q];
                    valid_q <= 1'b1;
                    state_q <= StXfer;
                end
                StXfer: begin
                    if (bus.bus_ready) begin
                        valid_q       <= 1'b0;
                        dst_q[cur_q]  <= dst_q[cur_q] + ADDR_W'(WORD_BYTES);
                        rem_q[cur_q]  <= rem_q[cur_q] - LEN_W'(1);
                        beat_q        <= beat_q + 1'b1;
                        if (rem_q[cur_q] == LEN_W'(1)) begin
                            done_q[cur_q] <= 1'b1;
                            state_q       <= StArb;
                        end else if ((beat_q + 1'b1) < BeatW'(BURST) && !empty[cur_q]) begin
                            rd_q[cur_q] <= 1'b1;
                            state_q     <= StRead;
                        end else begin
                            state_q <= StArb;
                        end
                    end
                end
                default: state_q <= StArb;
            endcase
        end
    end

    assign rd_0 = rd_q[0];
    assign rd_1 = rd_q[1];
    assign rd_2 = rd_q[2];
    assign rd_3 = rd_q[3];

    assign ch_done       = done_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;

endmodule
